sign_packer: RTL and testbench

- Reader side of the per-dimension bundling counters: snapshots the parallel sign_bit vector of all counters and streams it out as 32-bit words over a valid/ready stream, toward the DMA/host result path.
- Waits a fixed settle delay after the capture request so the counters' 3-stage update pipeline has drained before the snapshot.
- One snapshot per hypervector. Sequential parts: settle counter, word index, 3-state FSM.

---
 rtl/sign_packer.sv | 114 +++++++++++
 tb/tb_sign_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sign_packer.sv
// sign_packer: snapshots the DIM-bit sign vector of the bundling counters after
// a settle delay and streams it out as DIM/32 words over a valid/ready stream.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   sign_bits   sign bit of counter k on bit k
//   capture     one-cycle snapshot request
//   dout        packed 32-bit word (word i = sign_bits[32*i+31:32*i])
//   dout_valid  dout holds a valid word
//   dout_ready  downstream accepts on dout_valid && dout_ready
//   dout_last   high with the final word of a snapshot
//   busy        high whenever the block is not idle
//   overrun     sticky: a capture was dropped because the block was busy
module sign_packer #(
    parameter int unsigned DIM    = 1024,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned CW     = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DIM-1:0] sign_bits,
    input  logic           capture,
    output logic [31:0]    dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           dout_last,
    output logic           busy,
    output logic           overrun
);

    localparam int unsigned NW = DIM / 32;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SEND
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [DIM-1:0]  snap;
    logic [IW-1:0]   nxt_idx_c;

    // Index of the word that follows the one currently presented.
    assign nxt_idx_c = idx + IW'(1);

    // Control FSM with registered stream outputs; the next word is preloaded
    // from the snapshot so dout never depends combinationally on dout_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Any capture outside IDLE (including the last-handshake cycle) is dropped.
            if (capture && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (capture) begin
                        state <= S_SETTLE;
                        cnt   <= CW'(SETTLE - 1);
                        busy  <= 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (cnt == '0) begin
                        // Counters have drained: take the snapshot and present word 0.
                        snap       <= sign_bits;
                        idx        <= '0;
                        dout       <= sign_bits[31:0];
                        dout_valid <= 1'b1;
                        dout_last  <= (NW == 1);
                        state      <= S_SEND;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_SEND: begin
                    if (dout_ready) begin
                        if (dout_last) begin
                            state      <= S_IDLE;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            idx       <= nxt_idx_c;
                            dout      <= snap[{nxt_idx_c, 5'b0} +: 32];
                            dout_last <= (nxt_idx_c == IW'(NW - 1));
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_packer.sv
// tb_sign_packer: directed + randomized bench for sign_packer (DIM=128,
// SETTLE=4) with a transaction-level reference model (pending capture
// time + queue of expected words).
module tb_sign_packer;

    localparam int unsigned DIM    = 128;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned CW     = 8;
    localparam int unsigned NW     = DIM / 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [DIM-1:0] sign_bits;
    logic           capture;
    logic [31:0]    dout;
    logic           dout_valid;
    logic           dout_ready;
    logic           dout_last;
    logic           busy;
    logic           overrun;

    sign_packer #(.DIM(DIM), .SETTLE(SETTLE), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sign_bits (sign_bits),
        .capture   (capture),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model state
    logic [31:0] m_q[$];
    bit          m_pending;
    int          m_snap_edge;
    bit          m_ovr;
    int          m_edge;
    int          m_hs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return m_pending || (m_q.size() > 0);
    endfunction

    task automatic check_outputs();
        chk("valid", 32'(dout_valid), 32'(m_q.size() > 0));
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_q.size() > 0) begin
            chk("dout", dout, m_q[0]);
            chk("last", 32'(dout_last), 32'(m_q.size() == 1));
        end
    endtask

    // One clock: drive inputs, advance model at the edge, check just after it.
    task automatic step(input logic cap, input logic rdy, input logic [DIM-1:0] sb);
        bit was_busy;
        capture    = cap;
        dout_ready = rdy;
        sign_bits  = sb;
        @(posedge clk);
        m_edge++;
        was_busy = m_busy();
        if (cap && was_busy) m_ovr = 1'b1;
        if ((m_q.size() > 0) && rdy) begin
            void'(m_q.pop_front());
            m_hs++;
        end
        if (m_pending && (m_edge == m_snap_edge)) begin
            for (int w = 0; w < int'(NW); w++) m_q.push_back(sb[32*w +: 32]);
            m_pending = 1'b0;
        end
        if (cap && !was_busy) begin
            m_pending   = 1'b1;
            m_snap_edge = m_edge + int'(SETTLE);
        end
        #1;
        check_outputs();
    endtask

    function automatic logic [DIM-1:0] rnd_vec();
        logic [DIM-1:0] v;
        for (int w = 0; w < int'(NW); w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    // Run with ready=1 until the model is idle; an expired bound is a failure.
    task automatic drain(input logic [DIM-1:0] sb);
        int n;
        n = 0;
        while (m_busy() && n < 40) begin
            step(1'b0, 1'b1, sb);
            n++;
        end
        chk("drain_timeout", 32'(m_busy()), 32'd0);
    endtask

    initial begin
        logic [DIM-1:0] v;
        int t_cap;
        int t_valid;
        int hs0;

        m_pending = 0; m_ovr = 0; m_edge = 0; m_snap_edge = 0; m_hs = 0;
        rst = 1'b0; capture = 1'b0; dout_ready = 1'b0; sign_bits = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_dout", dout, 32'd0);
        chk("rst_last", 32'(dout_last), 32'd0);
        rst = 1'b1;

        // Directed: known pattern, ready held, check first-valid latency.
        v = rnd_vec();
        v[63:0] = 64'hDEADBEEF_01234567;
        step(1'b1, 1'b1, v);
        t_cap = m_edge;
        t_valid = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, v);
            if (dout_valid && t_valid < 0) begin
                t_valid = m_edge;
                chk("word0_const", dout, 32'h01234567);
            end
            if (t_valid >= 0 && m_edge == t_valid + 1) chk("word1_const", dout, 32'hDEADBEEF);
        end
        chk("latency", 32'(t_valid - t_cap), 32'(SETTLE));

        // Settle timing: input flips exactly at the sampled cycle, then one cycle later.
        step(1'b1, 1'b1, '0);
        for (int i = 1; i < int'(SETTLE); i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '1);
        chk("settle_ones", dout, 32'hFFFFFFFF);
        drain('1);
        step(1'b1, 1'b1, '0);
        for (int i = 1; i <= int'(SETTLE); i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '1);
        chk("settle_zero", dout, 32'h0);
        drain('1);

        // Backpressure: ready 1,0,0 repeating; sign_bits changes after snapshot.
        v = rnd_vec();
        hs0 = m_hs;
        step(1'b1, 1'b0, v);
        for (int i = 0; i < 30; i++) step(1'b0, (i % 3) == 0, rnd_vec());
        chk("bp_handshakes", 32'(m_hs - hs0), 32'(NW));
        drain(v);

        // Overrun: extra captures during SETTLE and during SEND.
        hs0 = m_hs;
        v = rnd_vec();
        step(1'b1, 1'b1, v);
        step(1'b0, 1'b1, v);
        step(1'b1, 1'b1, v);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v);
        step(1'b1, 1'b0, v);
        chk("ovr_set", 32'(overrun), 32'd1);
        drain(v);
        chk("ovr_words", 32'(m_hs - hs0), 32'(NW));
        step(1'b1, 1'b1, rnd_vec());
        drain(rnd_vec());
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-SEND after the word 1 handshake.
        step(1'b1, 1'b1, rnd_vec());
        for (int i = 0; i < int'(SETTLE) + 2; i++) step(1'b0, 1'b1, rnd_vec());
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovr", 32'(overrun), 32'd0);
        m_q.delete(); m_pending = 0; m_ovr = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd_vec());
        chk("post_rst_idle", 32'(dout_valid), 32'd0);
        v = rnd_vec();
        step(1'b1, 1'b1, v);
        for (int i = 0; i < int'(SETTLE); i++) step(1'b0, 1'b1, v);
        chk("post_rst_word0", dout, v[31:0]);

        // Back-to-back: capture in the first idle cycle after the last handshake.
        drain(v);
        v = rnd_vec();
        step(1'b1, 1'b1, v);
        t_cap = m_edge;
        for (int i = 0; i < int'(SETTLE); i++) step(1'b0, 1'b1, v);
        chk("b2b_valid", 32'(dout_valid), 32'd1);
        chk("b2b_lat", 32'(m_edge - t_cap), 32'(SETTLE));
        chk("b2b_no_ovr", 32'(overrun), 32'd0);
        drain(v);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0), rnd_vec());
        drain(rnd_vec());

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
